actuated_phase_scheduler: RTL and testbench



---
 rtl/traffic_pkg.sv | 30 +++
 rtl/rr_phase_picker.sv | 39 +++
 rtl/actuated_phase_scheduler.sv | 162 ++++++++++++++++
 tb/tb_actuated_phase_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types for the actuated phase scheduler:
//   state_t      - controller state (all-red clearance, green, yellow)
//   phase_t      - 2-bit phase index for the 4-phase intersection
//   phase_mask_t - one bit per phase (lamps, call memory)
//   onehot()     - phase index to phase mask
// -----------------------------------------------------------------------------
package traffic_pkg;

   localparam int NUM_PHASES = 4;

   typedef logic [1:0]            phase_t;
   typedef logic [NUM_PHASES-1:0] phase_mask_t;

   // Encoding 2'b11 is unused and recovers to S_ALL_RED.
   typedef enum logic [1:0] {
      S_ALL_RED = 2'd0,
      S_GREEN   = 2'd1,
      S_YELLOW  = 2'd2
   } state_t;

   function automatic phase_mask_t onehot(input phase_t p);
      phase_mask_t m;
      m    = '0;
      m[p] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/rr_phase_picker.sv
// -----------------------------------------------------------------------------
// rr_phase_picker
// Combinational round-robin search over the call memory. Starts one past the
// active phase and wraps, so the active phase itself is checked last.
// Ports:
//   pending      in  4  latched calls
//   active_phase in  2  last served / currently served phase
//   pick         out 2  first pending phase in round-robin order
//   any_valid    out 1  at least one call is pending
// -----------------------------------------------------------------------------
module rr_phase_picker
   import traffic_pkg::*;
(
   input  phase_mask_t pending,
   input  phase_t      active_phase,
   output phase_t      pick,
   output logic        any_valid
);

   phase_t w_idx;

   // Walk from the farthest candidate (offset 4 = active phase) to the
   // nearest (offset 1); the last hit written is the highest priority.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // otherwise an unassigned path infers a latch.
      pick      = active_phase;
      any_valid = 1'b0;
      w_idx     = '0;
      for (int k = NUM_PHASES; k >= 1; k--) begin
         w_idx = active_phase + phase_t'(k);
         if (pending[w_idx]) begin
            pick      = w_idx;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/actuated_phase_scheduler.sv
// -----------------------------------------------------------------------------
// actuated_phase_scheduler
// Demand-actuated 4-phase signal scheduler. Latches vehicle calls, grants
// phases round-robin and enforces min-green / max-green / yellow / all-red.
// Rests in green with no competing demand, rests in all-red with no demand.
// Optional feature macro: SCHED_PREEMPT_EN (emergency preemption ports).
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   det[3:0]           per-phase detector (level or pulse)
//   preempt            (SCHED_PREEMPT_EN) preemption request, level
//   preempt_phase[1:0] (SCHED_PREEMPT_EN) phase to serve under preemption
//   green[3:0]         one-hot green lamps
//   yellow[3:0]        one-hot yellow lamps
//   all_red            no phase green or yellow
//   active_phase[1:0]  phase being served / last served
//   pending[3:0]       latched call memory
//   phase_start        pulse on the first green cycle of a grant
// -----------------------------------------------------------------------------
module actuated_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int CNT_WIDTH        = 16,
   parameter int MIN_GREEN_CYCLES = 20,
   parameter int MAX_GREEN_CYCLES = 60,
   parameter int YELLOW_CYCLES    = 5,
   parameter int ALL_RED_CYCLES   = 2
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] det,
`ifdef SCHED_PREEMPT_EN
   input  logic       preempt,
   input  logic [1:0] preempt_phase,
`endif
   output logic [3:0] green,
   output logic [3:0] yellow,
   output logic       all_red,
   output logic [1:0] active_phase,
   output logic [3:0] pending,
   output logic       phase_start
);

   localparam logic [CNT_WIDTH-1:0] L_MIN_LAST = CNT_WIDTH'(MIN_GREEN_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] L_MAX_LAST = CNT_WIDTH'(MAX_GREEN_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] L_YEL_LAST = CNT_WIDTH'(YELLOW_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] L_AR_LAST  = CNT_WIDTH'(ALL_RED_CYCLES - 1);

   state_t                r_state, w_next_state;
   logic [CNT_WIDTH-1:0]  r_timer;
   phase_mask_t           r_pending, w_pending_next, w_clr, w_det_mask;
   phase_t                r_active_phase, w_next_phase, w_pick;
   logic                  w_any_valid, w_others, w_min_done;
`ifdef SCHED_PREEMPT_EN
   // Set while the current green was granted by preemption; lets the phase
   // skip min-green once the request is released.
   logic                  r_pre_hold, w_pre_hold_next;
`endif

   rr_phase_picker u_picker (
      .pending      (r_pending),
      .active_phase (r_active_phase),
      .pick         (w_pick),
      .any_valid    (w_any_valid)
   );

   assign w_others = |(r_pending & ~onehot(r_active_phase));

   always_comb begin
      w_next_state = r_state;
      w_next_phase = r_active_phase;
      w_clr        = '0;
      w_min_done   = (r_timer >= L_MIN_LAST);
`ifdef SCHED_PREEMPT_EN
      w_pre_hold_next = r_pre_hold;
      if (r_pre_hold) w_min_done = 1'b1;
`endif
      case (r_state)
         S_ALL_RED: begin
            if (r_timer >= L_AR_LAST) begin
`ifdef SCHED_PREEMPT_EN
               if (preempt) begin
                  w_next_state    = S_GREEN;
                  w_next_phase    = preempt_phase;
                  w_clr           = onehot(preempt_phase);
                  w_pre_hold_next = 1'b1;
               end else
`endif
               if (w_any_valid) begin
                  w_next_state = S_GREEN;
                  w_next_phase = w_pick;
                  w_clr        = onehot(w_pick);
`ifdef SCHED_PREEMPT_EN
                  w_pre_hold_next = 1'b0;
`endif
               end
            end
         end
         S_GREEN: begin
`ifdef SCHED_PREEMPT_EN
            if (preempt) begin
               if (preempt_phase != r_active_phase) w_next_state = S_YELLOW;
            end else
`endif
            // Extension only while the served phase keeps calling and max
            // green has not been reached; with no competition, rest here.
            if (w_min_done && w_others &&
                !(det[r_active_phase] && (r_timer < L_MAX_LAST))) begin
               w_next_state = S_YELLOW;
            end
         end
         S_YELLOW: begin
            if (r_timer >= L_YEL_LAST) w_next_state = S_ALL_RED;
         end
         default: w_next_state = S_ALL_RED;
      endcase
`ifdef SCHED_PREEMPT_EN
      if (w_next_state != S_GREEN) w_pre_hold_next = 1'b0;
`endif
   end

   // The green phase's own detector is ignored only while it stays green, so a
   // call seen on the edge that ends the green is kept for a later grant.
   assign w_det_mask     = ((r_state == S_GREEN) && (w_next_state == S_GREEN)) ?
                           onehot(r_active_phase) : '0;
   assign w_pending_next = (r_pending | (det & ~w_det_mask)) & ~w_clr;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_state        <= S_ALL_RED;
         r_timer        <= '0;
         r_pending      <= '0;
         r_active_phase <= 2'd3;
`ifdef SCHED_PREEMPT_EN
         r_pre_hold     <= 1'b0;
`endif
      end else begin
         r_state        <= w_next_state;
         r_active_phase <= w_next_phase;
         r_pending      <= w_pending_next;
`ifdef SCHED_PREEMPT_EN
         r_pre_hold     <= w_pre_hold_next;
`endif
         // Timer restarts on any state change and saturates rather than wraps.
         if (w_next_state != r_state) r_timer <= '0;
         else if (r_timer != '1)      r_timer <= r_timer + 1'b1;
      end
   end

   // Moore decode from registered state only.
   always_comb begin
      green       = (r_state == S_GREEN)  ? onehot(r_active_phase) : 4'b0000;
      yellow      = (r_state == S_YELLOW) ? onehot(r_active_phase) : 4'b0000;
      all_red     = !((r_state == S_GREEN) || (r_state == S_YELLOW));
      phase_start = (r_state == S_GREEN) && (r_timer == '0);
   end

   assign active_phase = r_active_phase;
   assign pending      = r_pending;

endmodule

// File: tb/tb_actuated_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_actuated_phase_scheduler
// Directed bench with an interval-level reference model (lamp kind + cycles
// spent in the current interval + call set) compared every cycle, plus
// hand-computed expectations for the scenarios of interest.
// Configuration: MIN=4, MAX=8, YELLOW=2, ALL_RED=1, 4-bit timer so a long
// rest in green drives the timer into saturation.
// -----------------------------------------------------------------------------
module tb_actuated_phase_scheduler;

   localparam int P_MIN = 4;
   localparam int P_MAX = 8;
   localparam int P_YEL = 2;
   localparam int P_AR  = 1;

   localparam int K_RED = 0;
   localparam int K_GRN = 1;
   localparam int K_YEL = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] det = 4'b0000;
   logic [3:0] green, yellow, pending;
   logic       all_red, phase_start;
   logic [1:0] active_phase;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   actuated_phase_scheduler #(
      .CNT_WIDTH        (4),
      .MIN_GREEN_CYCLES (P_MIN),
      .MAX_GREEN_CYCLES (P_MAX),
      .YELLOW_CYCLES    (P_YEL),
      .ALL_RED_CYCLES   (P_AR)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .det          (det),
      .green        (green),
      .yellow       (yellow),
      .all_red      (all_red),
      .active_phase (active_phase),
      .pending      (pending),
      .phase_start  (phase_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int       m_kind, m_age, m_phase;
   bit [3:0] m_calls;

   always @(posedge clk) begin
      int       nk, gp;
      bit       others;
      bit [3:0] nc;
      if (!rst_n) begin
         m_kind  <= K_RED;
         m_age   <= 0;
         m_phase <= 3;
         m_calls <= 4'b0000;
      end else begin
         nk = m_kind;
         gp = -1;
         others = 1'b0;
         for (int j = 0; j < 4; j++) if (j != m_phase && m_calls[j]) others = 1'b1;
         if (m_kind == K_RED) begin
            if (m_age >= P_AR - 1 && m_calls != 4'b0000) begin
               for (int k = 1; k <= 4; k++)
                  if (gp < 0 && m_calls[(m_phase + k) % 4]) gp = (m_phase + k) % 4;
               nk = K_GRN;
            end
         end else if (m_kind == K_GRN) begin
            if (m_age >= P_MIN - 1 && others && !(det[m_phase] && m_age < P_MAX - 1))
               nk = K_YEL;
         end else begin
            if (m_age >= P_YEL - 1) nk = K_RED;
         end
         for (int i = 0; i < 4; i++) begin
            nc[i] = m_calls[i] | (det[i] && !(m_kind == K_GRN && nk == K_GRN && i == m_phase));
            if (i == gp) nc[i] = 1'b0;
         end
         m_calls <= nc;
         m_age   <= (nk == m_kind) ? m_age + 1 : 0;
         m_kind  <= nk;
         if (gp >= 0) m_phase <= gp;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_green",   green,        (m_kind == K_GRN) ? (32'd1 << m_phase) : 32'd0);
         check("model_yellow",  yellow,       (m_kind == K_YEL) ? (32'd1 << m_phase) : 32'd0);
         check("model_all_red", all_red,      (m_kind == K_RED) ? 32'd1 : 32'd0);
         check("model_active",  active_phase, m_phase);
         check("model_pending", pending,      m_calls);
         check("model_pstart",  phase_start,  (m_kind == K_GRN && m_age == 0) ? 32'd1 : 32'd0);
      end
   end

   // ---------------- stimulus helpers ----------------
   // One clock edge with the given detector value; returns at the following
   // falling edge with outputs settled.
   task automatic step(input logic [3:0] d);
      det = d;
      @(negedge clk);
   endtask

   task automatic wait_green(input logic [3:0] mask, input string name);
      int n;
      n = 0;
      while (green !== mask && n < 100) begin
         step(4'b0000);
         n++;
      end
      check(name, green, mask);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(4'b0000);
      rst_n = 1'b1;
      check("rst_all_red", all_red, 1);
      check("rst_pending", pending, 0);
      check("rst_active",  active_phase, 3);
   endtask

   initial begin
      int       cnt;
      int       grants[$];
      logic [3:0] d;

      @(negedge clk);
      step(4'b0000);
      cmp_en = 1'b1;
      check("reset_green",   green, 0);
      check("reset_yellow",  yellow, 0);
      check("reset_all_red", all_red, 1);
      check("reset_pstart",  phase_start, 0);
      check("reset_active",  active_phase, 3);
      rst_n = 1'b1;

      // Idle: rest in all-red.
      for (int i = 0; i < 10; i++) step(4'b0000);
      check("idle_all_red", all_red, 1);
      check("idle_pending", pending, 0);

      // Single-cycle call on phase 2: latched next edge, green the edge after.
      step(4'b0100);
      check("p2_latched", pending, 4'b0100);
      check("p2_still_red", all_red, 1);
      step(4'b0000);
      check("p2_green", green, 4'b0100);
      check("p2_pstart", phase_start, 1);
      check("p2_cleared", pending, 0);
      for (int i = 0; i < 50; i++) step(4'b0000);
      check("p2_rest_green", green, 4'b0100);
      check("p2_rest_nopulse", phase_start, 0);

      // Extension to max green: det[0] held, det[1] pulsed on green cycle 1.
      do_reset();
      step(4'b0001);
      step(4'b0001);
      check("ext_green0", green, 4'b0001);
      cnt = 1;
      step(4'b0011);
      while (green === 4'b0001 && cnt < 40) begin
         cnt++;
         step(4'b0001);
      end
      check("ext_green_len", cnt, P_MAX);
      cnt = 0;
      while (yellow === 4'b0001 && cnt < 40) begin
         cnt++;
         step(4'b0001);
      end
      check("ext_yellow_len", cnt, P_YEL);
      cnt = 0;
      while (all_red === 1'b1 && cnt < 40) begin
         cnt++;
         step(4'b0001);
      end
      check("ext_red_len", cnt, P_AR);
      check("ext_next_green", green, 4'b0010);

      // Phase 1 now serves with phase 0 waiting; then phase 0 at min green
      // against a phase-3 call.
      wait_green(4'b0001, "min_wait_green0");
      cnt = 1;
      step(4'b1000);
      while (green === 4'b0001 && cnt < 40) begin
         cnt++;
         step(4'b0000);
      end
      check("min_green_len", cnt, P_MIN);
      cnt = 0;
      while (yellow === 4'b0001 && cnt < 40) begin
         cnt++;
         step(4'b0000);
      end
      check("min_yellow_len", cnt, P_YEL);
      step(4'b0000);
      check("min_next_green", green, 4'b1000);

      // All four calls with phase 1 leaving: grant order 2, 3, 0, 1.
      do_reset();
      step(4'b0010);
      step(4'b0000);
      check("rr_green1", green, 4'b0010);
      cnt = 0;
      while (green === 4'b0010 && cnt < 40) begin
         cnt++;
         step(4'b1111);
      end
      check("rr_green1_len", cnt, P_MAX);
      check("rr_relatch", pending, 4'b1111);
      cnt = 0;
      while (grants.size() < 4 && cnt < 200) begin
         step(4'b0000);
         if (phase_start === 1'b1) grants.push_back(int'(active_phase));
         cnt++;
      end
      check("rr_grant_count", grants.size(), 4);
      for (int i = 0; i < grants.size() && i < 4; i++) begin
         d = 4'((i + 2) % 4);
         check("rr_grant_order", grants[i], d);
      end
      check("rr_pending_empty", pending, 0);

      // Reset in the middle of yellow[1].
      step(4'b0001);
      cnt = 0;
      while (yellow !== 4'b0010 && cnt < 100) begin
         step(4'b0000);
         cnt++;
      end
      check("ry_in_yellow", yellow, 4'b0010);
      step(4'b0100);
      rst_n = 1'b0;
      step(4'b0000);
      rst_n = 1'b1;
      check("ry_all_red", all_red, 1);
      check("ry_yellow",  yellow, 0);
      check("ry_pending", pending, 0);
      check("ry_active",  active_phase, 3);
      for (int i = 0; i < 5; i++) step(4'b0000);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
